// File: rtl/wdog_if.sv
// Host register-write bus feeding the watchdog.
interface wdog_if;
    logic [15:0] reg_waddr;
    logic [31:0] reg_wdata;
    logic        reg_wen;

    modport master (output reg_waddr, output reg_wdata, output reg_wen);
    modport slave  (input  reg_waddr, input  reg_wdata, input  reg_wen);
endinterface

// File: rtl/wdog_timer.sv
// Host-communication watchdog: programmable period in prescaled ticks, sticky timeout,
// cleared by a power-enable command or a period rewrite.
module wdog_timer #(
    parameter int unsigned PRESCALE_BITS = 8,
    parameter int unsigned LED_SHIFT     = 6,
    parameter logic [3:0]  ADDR_MAIN     = 4'h0,
    parameter logic [3:0]  REG_WDOG      = 4'hB
) (
    input  logic        sysclk,
    input  logic        reset_n,
    wdog_if.slave       bus,
    input  logic        wdog_refresh,
    input  logic        pwr_enable_cmd,
    output logic [15:0] wdog_period,
    output logic        wdog_timeout,
    output logic        wdog_led,
    output logic [1:0]  wdog_state
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_RUNNING  = 2'b01,
        ST_EXPIRED  = 2'b10
    } state_t;

    state_t                   state;
    logic [PRESCALE_BITS-1:0] presc;
    logic [CNT_W-1:0]         cnt;

    logic             period_wr_c;
    logic             tick_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             unused_bits;

    assign period_wr_c = bus.reg_wen
                      && (bus.reg_waddr[15:12] == ADDR_MAIN)
                      && (bus.reg_waddr[7:4]   == 4'h0)
                      && (bus.reg_waddr[3:0]   == REG_WDOG);
    assign tick_c      = (presc == {PRESCALE_BITS{1'b1}});
    assign cnt_inc_c   = cnt + CNT_W'(1);
    assign unused_bits = ^{bus.reg_wdata[31:16], bus.reg_waddr[11:8]};

    assign wdog_state  = state;

    // Event priority: reset, period write, power-enable, refresh, expiry tick.
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            state        <= ST_DISABLED;
            presc        <= '0;
            cnt          <= '0;
            wdog_period  <= '0;
            wdog_timeout <= 1'b0;
            wdog_led     <= 1'b0;
        end else if (period_wr_c) begin
            wdog_period  <= bus.reg_wdata[15:0];
            presc        <= '0;
            cnt          <= '0;
            wdog_timeout <= 1'b0;
            wdog_led     <= 1'b0;
            state        <= (bus.reg_wdata[15:0] == 16'h0) ? ST_DISABLED : ST_RUNNING;
        end else begin
            unique case (state)
                ST_DISABLED: begin
                    wdog_led <= 1'b0;
                end
                ST_RUNNING: begin
                    if (pwr_enable_cmd || wdog_refresh) begin
                        presc    <= '0;
                        cnt      <= '0;
                        wdog_led <= 1'b0;
                    end else if (tick_c) begin
                        presc <= '0;
                        cnt   <= cnt_inc_c;
                        if (cnt_inc_c == wdog_period) begin
                            state        <= ST_EXPIRED;
                            wdog_timeout <= 1'b1;
                            wdog_led     <= 1'b1;
                        end else begin
                            wdog_led <= cnt_inc_c[LED_SHIFT];
                        end
                    end else begin
                        presc <= presc + PRESCALE_BITS'(1);
                    end
                end
                ST_EXPIRED: begin
                    // Refresh alone is ignored here; only power-enable re-arms.
                    if (pwr_enable_cmd) begin
                        wdog_timeout <= 1'b0;
                        presc        <= '0;
                        cnt          <= '0;
                        wdog_led     <= 1'b0;
                        state        <= (wdog_period != 16'h0) ? ST_RUNNING : ST_DISABLED;
                    end else begin
                        wdog_timeout <= 1'b1;
                        wdog_led     <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_DISABLED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wdog_timer.sv
// Scoreboard bench for wdog_timer: expectations are queued by absolute cycle when
// stimulus is driven and compared on the falling edge once that cycle is reached.
module tb_wdog_timer;

    localparam logic [15:0] A_WDOG = 16'h000B;

    localparam int SEL_TO  = 0;
    localparam int SEL_ST  = 1;
    localparam int SEL_LED = 2;
    localparam int SEL_PER = 3;

    logic        sysclk;
    logic        reset_n;
    logic        wdog_refresh;
    logic        pwr_enable_cmd;
    logic [15:0] wdog_period;
    logic        wdog_timeout;
    logic        wdog_led;
    logic [1:0]  wdog_state;

    wdog_if bus ();

    wdog_timer dut (
        .sysclk         (sysclk),
        .reset_n        (reset_n),
        .bus            (bus.slave),
        .wdog_refresh   (wdog_refresh),
        .pwr_enable_cmd (pwr_enable_cmd),
        .wdog_period    (wdog_period),
        .wdog_timeout   (wdog_timeout),
        .wdog_led       (wdog_led),
        .wdog_state     (wdog_state)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int unsigned cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        int          sel;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_TO:  return 32'(wdog_timeout);
            SEL_ST:  return 32'(wdog_state);
            SEL_LED: return 32'(wdog_led);
            default: return 32'(wdog_period);
        endcase
    endfunction

    task automatic expect_at(input int unsigned at, input int sel, input logic [31:0] v,
                             input string tag);
        exp_t e;
        int   i;
        e.cyc = at;
        e.sel = sel;
        e.exp = v;
        e.tag = tag;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= at) i++;
        sb.insert(i, e);
    endtask

    always @(negedge sysclk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            chk(mon_e.tag, observe(mon_e.sel), mon_e.exp);
        end
    end

    task automatic wait_to(input int unsigned t);
        while (cyc < t) @(negedge sysclk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, output int unsigned w);
        @(negedge sysclk);
        bus.reg_waddr = a;
        bus.reg_wdata = d;
        bus.reg_wen   = 1'b1;
        @(negedge sysclk);
        bus.reg_wen   = 1'b0;
        w = cyc;
    endtask

    // which: 0 = wdog_refresh, 1 = pwr_enable_cmd
    task automatic pulse(input int which, output int unsigned w);
        @(negedge sysclk);
        if (which == 0) wdog_refresh = 1'b1;
        else            pwr_enable_cmd = 1'b1;
        @(negedge sysclk);
        wdog_refresh   = 1'b0;
        pwr_enable_cmd = 1'b0;
        w = cyc;
    endtask

    initial begin
        int unsigned w;
        int unsigned r;

        reset_n        = 1'b0;
        wdog_refresh   = 1'b0;
        pwr_enable_cmd = 1'b0;
        bus.reg_waddr  = '0;
        bus.reg_wdata  = '0;
        bus.reg_wen    = 1'b0;
        repeat (3) @(negedge sysclk);
        expect_at(cyc + 1, SEL_TO,  0, "rst_timeout");
        expect_at(cyc + 1, SEL_ST,  0, "rst_state");
        expect_at(cyc + 1, SEL_LED, 0, "rst_led");
        expect_at(cyc + 1, SEL_PER, 0, "rst_period");
        reset_n = 1'b1;

        // Period 4, no refresh: expiry exactly 1024 edges after the write.
        wr(A_WDOG, 32'h0000_0004, w);
        expect_at(w + 1,    SEL_PER, 4, "t1_period");
        expect_at(w + 1,    SEL_ST,  1, "t1_running");
        expect_at(w + 1023, SEL_TO,  0, "t1_before_expiry");
        expect_at(w + 1024, SEL_TO,  1, "t1_expired");
        expect_at(w + 1024, SEL_ST,  2, "t1_state_exp");
        expect_at(w + 1024, SEL_LED, 1, "t1_led_exp");
        wait_to(w + 1030);

        // Refresh does not clear EXPIRED; power-enable does and re-arms.
        for (int k = 0; k < 3; k++) begin
            pulse(0, r);
            expect_at(r + 1, SEL_TO, 1, "t3_refresh_sticky");
            expect_at(r + 1, SEL_ST, 2, "t3_refresh_state");
        end
        @(negedge sysclk);
        pwr_enable_cmd = 1'b1;
        expect_at(cyc + 1, SEL_TO,  0, "t3_pwr_clear");
        expect_at(cyc + 1, SEL_ST,  1, "t3_pwr_running");
        expect_at(cyc + 1, SEL_LED, 0, "t3_pwr_led");
        @(negedge sysclk);
        pwr_enable_cmd = 1'b0;
        r = cyc;
        expect_at(r + 1023, SEL_TO, 0, "t3_rearm_before");
        expect_at(r + 1024, SEL_TO, 1, "t3_rearm_expired");
        wait_to(r + 1030);

        // Periodic refresh keeps the watchdog quiet; upper data bits ignored.
        wr(A_WDOG, 32'hABCD_0004, w);
        expect_at(w + 1,     SEL_PER, 4, "t2_upper_ignored");
        expect_at(w + 1,     SEL_TO,  0, "t2_write_clears");
        expect_at(w + 2000,  SEL_TO,  0, "t2_quiet_2000");
        expect_at(w + 5000,  SEL_TO,  0, "t2_quiet_5000");
        expect_at(w + 10000, SEL_TO,  0, "t2_quiet_10000");
        expect_at(w + 10000, SEL_ST,  1, "t2_state_10000");
        for (int k = 1; k <= 12; k++) begin
            wait_to(w + 800 * k - 1);
            pulse(0, r);
        end
        wait_to(w + 10001);

        // Refresh landing on the expiry tick wins.
        wr(A_WDOG, 32'h0000_0004, w);
        wait_to(w + 1023);
        wdog_refresh = 1'b1;
        expect_at(w + 1024, SEL_TO, 0, "t2_coincident_refresh");
        expect_at(w + 1024, SEL_ST, 1, "t2_coincident_state");
        @(negedge sysclk);
        wdog_refresh = 1'b0;
        r = cyc;
        expect_at(r + 1023, SEL_TO, 0, "t2_after_coinc_before");
        expect_at(r + 1024, SEL_TO, 1, "t2_after_coinc_expired");
        wait_to(r + 1030);

        // Write 0 disables; mis-addressed writes are ignored.
        wr(A_WDOG, 32'h0000_0100, w);
        wait_to(w + 500);
        wr(A_WDOG, 32'h0000_0000, w);
        expect_at(w + 1,    SEL_ST,  0, "t4_disabled");
        expect_at(w + 1,    SEL_TO,  0, "t4_timeout");
        expect_at(w + 1,    SEL_LED, 0, "t4_led");
        expect_at(w + 1,    SEL_PER, 0, "t4_period");
        expect_at(w + 5000, SEL_TO,  0, "t4_no_expiry");
        wait_to(w + 5000);
        wr(16'h001B, 32'h0000_0004, w);
        expect_at(w + 1, SEL_PER, 0, "t4_bad_sub_period");
        expect_at(w + 1, SEL_ST,  0, "t4_bad_sub_state");
        wr(16'h100B, 32'h0000_0004, w);
        expect_at(w + 1, SEL_PER, 0, "t4_bad_main_period");
        wait_to(w + 2);

        // Reset at count 3 of period 4 loses everything.
        wr(A_WDOG, 32'h0000_0004, w);
        wait_to(w + 800);
        reset_n = 1'b0;
        expect_at(w + 801, SEL_ST,  0, "t6_rst_state");
        expect_at(w + 801, SEL_TO,  0, "t6_rst_timeout");
        expect_at(w + 801, SEL_LED, 0, "t6_rst_led");
        expect_at(w + 801, SEL_PER, 0, "t6_rst_period");
        expect_at(w + 1100, SEL_TO, 0, "t6_no_expiry");
        @(negedge sysclk);
        reset_n = 1'b1;
        wait_to(w + 1100);

        // Write together with power-enable and refresh: write takes effect.
        @(negedge sysclk);
        bus.reg_waddr  = A_WDOG;
        bus.reg_wdata  = 32'h0000_0004;
        bus.reg_wen    = 1'b1;
        wdog_refresh   = 1'b1;
        pwr_enable_cmd = 1'b1;
        @(negedge sysclk);
        bus.reg_wen    = 1'b0;
        wdog_refresh   = 1'b0;
        pwr_enable_cmd = 1'b0;
        w = cyc;
        expect_at(w + 1,    SEL_PER, 4, "t6_simul_period");
        expect_at(w + 1,    SEL_ST,  1, "t6_simul_state");
        expect_at(w + 1023, SEL_TO,  0, "t6_simul_before");
        expect_at(w + 1024, SEL_TO,  1, "t6_simul_expired");
        wait_to(w + 1030);

        // Period 200: LED follows count bit 6, then steady after expiry.
        wr(A_WDOG, 32'h0000_00C8, w);
        expect_at(w + 16383, SEL_LED, 0, "t5_led_pre64");
        expect_at(w + 16384, SEL_LED, 1, "t5_led_64");
        expect_at(w + 32767, SEL_LED, 1, "t5_led_pre128");
        expect_at(w + 32768, SEL_LED, 0, "t5_led_128");
        expect_at(w + 49152, SEL_LED, 1, "t5_led_192");
        expect_at(w + 51199, SEL_TO,  0, "t5_before_expiry");
        expect_at(w + 51200, SEL_TO,  1, "t5_expired");
        expect_at(w + 51200, SEL_LED, 1, "t5_led_expired");
        expect_at(w + 51300, SEL_LED, 1, "t5_led_steady");
        wait_to(w + 51302);

        @(negedge sysclk);
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk({mon_e.tag, "_missed"}, ~mon_e.exp, mon_e.exp);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
